// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the RV64I execute-stage ALU:
//     - XLEN            datapath width (only 64 is supported)
//     - alu_op_e        4-bit operation select encoding
//     - bit_reverse()   bit-order reversal, lets one right shifter do left shifts
//     - sext_word()     sign-extend a 32-bit word result to XLEN
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SLL     = 4'b0100,
    ALU_SRL     = 4'b0101,
    ALU_SUB     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_SLT     = 4'b1000,
    ALU_SLTU    = 4'b1001,
    ALU_ADDW    = 4'b1010,
    ALU_SUBW    = 4'b1011,
    ALU_SLLW    = 4'b1100,
    ALU_SRLW    = 4'b1101,
    ALU_SRAW    = 4'b1110,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

  // Reverse bit order: bit i of the result is bit XLEN-1-i of v.
  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

  // Sign-extend a 32-bit word from bit 31 into the upper half.
  function automatic logic [XLEN-1:0] sext_word(input logic [31:0] w);
    return {{(XLEN-32){w[31]}}, w};
  endfunction

endpackage : alu_pkg

// File: rtl/alu_shifter.sv
// -----------------------------------------------------------------------------
// alu_shifter
//   Logarithmic (6-stage) barrel shifter for the ALU.
//
//   Ports:
//     data    [XLEN-1:0] in   value to shift
//     shamt   [5:0]      in   shift amount; bit 5 is ignored in word mode
//     dir                in   0 = left, 1 = right
//     arith              in   1 = arithmetic right shift (sign fill)
//     word               in   1 = 32-bit W shift, result sign-extended from bit 31
//     result  [XLEN-1:0] out  shifted value
//
//   Only a right shifter is built. Left shifts reverse the operand on the way
//   in and the result on the way out, so both directions share the mux stages.
// -----------------------------------------------------------------------------
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [5:0]      shamt,
  input  logic            dir,
  input  logic            arith,
  input  logic            word,
  output logic [XLEN-1:0] result
);

  localparam int STAGES = 6;

  logic [XLEN-1:0] operand;
  logic [5:0]      amt;
  logic            fill;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] stage [0:STAGES];

  // Word mode: prepare the low word as a 64-bit value so the same right
  // shifter yields the correct bits in [31:0]. SRAW needs the word's sign
  // bit in the upper half so that it is what gets shifted in; SRLW needs
  // zeros there. SLLW only keeps bits [31:0], so the upper half is irrelevant.
  // NOTE: every signal written in this block gets a value on every path
  // (here via if/else on each one); a missed path would infer a latch.
  always_comb begin
    if (word) begin
      operand = arith ? sext_word(data[31:0]) : {{(XLEN-32){1'b0}}, data[31:0]};
      amt     = {1'b0, shamt[4:0]};
    end else begin
      operand = data;
      amt     = shamt;
    end
  end

  // Sign fill applies only to right arithmetic shifts; left shifts fill zeros.
  assign fill = dir & arith & operand[XLEN-1];

  assign stage[0] = dir ? operand : bit_reverse(operand);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int STEP = 1 << k;
    assign stage[k+1] = amt[k] ? {{STEP{fill}}, stage[k][XLEN-1:STEP]} : stage[k];
  end

  assign shifted = dir ? stage[STAGES] : bit_reverse(stage[STAGES]);

  assign result = word ? sext_word(shifted[31:0]) : shifted;

endmodule : alu_shifter

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   64-bit RV64I integer ALU for the execute stage.
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst         in   synchronous, active-high reset (registered outputs only)
//     in1 [63:0]  in   operand A (rs1)
//     in2 [63:0]  in   operand B (rs2 or immediate)
//     ALUop [3:0] in   operation select, see alu_pkg::alu_op_e
//     out [63:0]  out  combinational result (don't-care for the reserved op)
//     Z           out  combinational zero flag, 1 when out == 0
//     illegal_op  out  combinational, 1 for the reserved encoding
//     out_q [63:0]out  out registered on clk, cleared by rst
//     z_q         out  Z registered on clk, cleared by rst
//
//   One shared adder serves ADD/SUB/ADDW/SUBW and both compares: the
//   subtract path inverts in2 and injects a carry-in of 1.
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [3:0]      ALUop,
  output logic [XLEN-1:0] out,
  output logic            Z,
  output logic            illegal_op,
  output logic [XLEN-1:0] out_q,
  output logic            z_q
);

  alu_op_e op;
  assign op = alu_op_e'(ALUop);

  // ---------------------------------------------------------------------------
  // Shared adder / subtractor
  // ---------------------------------------------------------------------------
  logic            sub_en;
  logic [XLEN:0]   sum_full;
  logic [XLEN-1:0] sum;
  logic            lt_signed;
  logic            lt_unsigned;

  assign sub_en = (op == ALU_SUB) || (op == ALU_SUBW) ||
                  (op == ALU_SLT) || (op == ALU_SLTU);

  assign sum_full = {1'b0, in1}
                  + {1'b0, in2 ^ {XLEN{sub_en}}}
                  + {{XLEN{1'b0}}, sub_en};
  assign sum      = sum_full[XLEN-1:0];

  // in1 - in2 borrows (carry-out 0) exactly when in1 < in2 unsigned.
  assign lt_unsigned = ~sum_full[XLEN];

  // Operands of different sign: the negative one is smaller, and the
  // difference may overflow, so decide on in1's sign. Same sign: the
  // difference cannot overflow and its sign bit is the answer.
  assign lt_signed = (in1[XLEN-1] ^ in2[XLEN-1]) ? in1[XLEN-1] : sum[XLEN-1];

  // ---------------------------------------------------------------------------
  // Shifter
  // ---------------------------------------------------------------------------
  logic            shift_dir;
  logic            shift_arith;
  logic            shift_word;
  logic [XLEN-1:0] shift_result;

  assign shift_dir   = (op == ALU_SRL)  || (op == ALU_SRA) ||
                       (op == ALU_SRLW) || (op == ALU_SRAW);
  assign shift_arith = (op == ALU_SRA)  || (op == ALU_SRAW);
  assign shift_word  = (op == ALU_SLLW) || (op == ALU_SRLW) || (op == ALU_SRAW);

  alu_shifter u_shifter (
    .data   (in1),
    .shamt  (in2[5:0]),
    .dir    (shift_dir),
    .arith  (shift_arith),
    .word   (shift_word),
    .result (shift_result)
  );

  // ---------------------------------------------------------------------------
  // Result select
  // ---------------------------------------------------------------------------
  // The reserved encoding drives X so synthesis may pick whatever is cheapest.
  always_comb begin
    out        = 'x;
    illegal_op = 1'b0;
    case (op)
      ALU_AND:  out = in1 & in2;
      ALU_OR:   out = in1 | in2;
      ALU_XOR:  out = in1 ^ in2;
      ALU_ADD,
      ALU_SUB:  out = sum;
      ALU_SLT:  out = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU: out = {{(XLEN-1){1'b0}}, lt_unsigned};
      // Low 32 bits of the 64-bit sum equal the 32-bit sum.
      ALU_ADDW,
      ALU_SUBW: out = sext_word(sum[31:0]);
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_SLLW,
      ALU_SRLW,
      ALU_SRAW: out = shift_result;
      default: begin
        out        = 'x;
        illegal_op = 1'b1;
      end
    endcase
  end

  assign Z = (out == '0);

  // ---------------------------------------------------------------------------
  // Pipeline register boundary
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its input as it was before the edge, regardless of block order.
  // NOTE: reset is synchronous and only clears the registered copy; the
  // combinational outputs never see it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      z_q   <= 1'b0;
    end else begin
      out_q <= out;
      z_q   <= Z;
    end
  end

endmodule : alu

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//   Self-checking bench for alu: directed vectors from the test plan, a
//   reset/registered-path sequence, then randomized operations compared with
//   a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in1;
  logic [63:0] in2;
  logic [3:0]  ALUop;
  logic [63:0] out;
  logic        Z;
  logic        illegal_op;
  logic [63:0] out_q;
  logic        z_q;

  int n_cmp = 0;
  int n_bad = 0;

  alu dut (
    .clk        (clk),
    .rst        (rst),
    .in1        (in1),
    .in2        (in2),
    .ALUop      (ALUop),
    .out        (out),
    .Z          (Z),
    .illegal_op (illegal_op),
    .out_q      (out_q),
    .z_q        (z_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference model straight from the RV64I operation definitions.
  function automatic void model(input logic [3:0] op, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] r,
                                output logic ill);
    logic [31:0] w;
    ill = 1'b0;
    r   = '0;
    w   = '0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = a << b[5:0];
      4'd5:  r = a >> b[5:0];
      4'd6:  r = a - b;
      4'd7:  r = $signed(a) >>> b[5:0];
      4'd8:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9:  r = (a < b) ? 64'd1 : 64'd0;
      4'd10: begin w = a[31:0] + b[31:0];            r = {{32{w[31]}}, w}; end
      4'd11: begin w = a[31:0] - b[31:0];            r = {{32{w[31]}}, w}; end
      4'd12: begin w = a[31:0] << b[4:0];            r = {{32{w[31]}}, w}; end
      4'd13: begin w = a[31:0] >> b[4:0];            r = {{32{w[31]}}, w}; end
      4'd14: begin w = $signed(a[31:0]) >>> b[4:0];  r = {{32{w[31]}}, w}; end
      default: ill = 1'b1;
    endcase
  endfunction

  // Drive one operation at the falling edge, check the combinational outputs,
  // then check the registered copy after the next rising edge.
  task automatic run_op(input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input string tag);
    logic [63:0] exp;
    logic        ill;
    @(negedge clk);
    ALUop = op;
    in1   = a;
    in2   = b;
    model(op, a, b, exp, ill);
    #1;
    check($sformatf("%s.illegal", tag), {63'b0, illegal_op}, {63'b0, ill});
    if (!ill) begin
      check($sformatf("%s.out", tag), out, exp);
      check($sformatf("%s.Z", tag), {63'b0, Z}, {63'b0, exp == 64'd0});
    end
    @(posedge clk);
    #1;
    if (!ill) begin
      if (rst) begin
        check($sformatf("%s.out_q_rst", tag), out_q, 64'd0);
        check($sformatf("%s.z_q_rst", tag), {63'b0, z_q}, 64'd0);
      end else begin
        check($sformatf("%s.out_q", tag), out_q, exp);
        check($sformatf("%s.z_q", tag), {63'b0, z_q}, {63'b0, exp == 64'd0});
      end
    end
  endtask

  function automatic logic [63:0] pick_operand(input int mode);
    logic [63:0] edges [0:5];
    edges[0] = 64'h0;
    edges[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    edges[2] = 64'h8000_0000_0000_0000;
    edges[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    edges[4] = 64'h0000_0000_8000_0000;
    edges[5] = 64'h0000_0000_7FFF_FFFF;
    case (mode)
      0:       return {$urandom(), $urandom()};
      1:       return 64'($urandom_range(0, 15));
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    rst   = 1'b1;
    in1   = '0;
    in2   = '0;
    ALUop = 4'b0000;

    // Reset for two edges; AND 0,0 makes Z=1, so z_q must be held at 0 by rst.
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_q", out_q, 64'd0);
    check("reset.z_q", {63'b0, z_q}, 64'd0);
    check("reset.Z_comb", {63'b0, Z}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Logic
    run_op(4'b0000, 64'd10, 64'd12, "and");
    run_op(4'b0001, 64'd10, 64'd12, "or");
    run_op(4'b0011, 64'd10, 64'd12, "xor");
    // Arithmetic
    run_op(4'b0010, 64'd10, 64'd12, "add");
    run_op(4'b0110, 64'd15, 64'd10, "sub");
    run_op(4'b0110, 64'd10, 64'd10, "sub_eq");
    run_op(4'b0000, 64'd0,  64'd0,  "and_zero");
    run_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "add_wrap");
    // Shifts / compare
    run_op(4'b0111, 64'h8000_0000_0000_0000, 64'd63, "sra63");
    run_op(4'b0100, 64'd1, 64'h41, "sll_hi_bits");
    run_op(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "slt_neg");
    run_op(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "sltu_big");
    run_op(4'b0101, 64'hDEAD_BEEF_0000_0001, 64'd0, "srl0");
    // W ops
    run_op(4'b1010, 64'h7FFF_FFFF, 64'd1, "addw");
    run_op(4'b1011, 64'h1234_5678_0000_0000, 64'd1, "subw");
    run_op(4'b1101, 64'hFFFF_FFFF_8000_0000, 64'd31, "srlw31");
    run_op(4'b1110, 64'h8000_0000, 64'd4, "sraw4");
    run_op(4'b1101, 64'h8000_0000, 64'd0, "srlw0");
    run_op(4'b1100, 64'h1, 64'h3F, "sllw_hi_bits");
    // Reserved encoding
    run_op(4'b1111, 64'd10, 64'd12, "illegal");

    // Reset mid-stream dominates the inputs; combinational path unaffected.
    rst = 1'b1;
    run_op(4'b0010, 64'd10, 64'd12, "rst_add");
    run_op(4'b0110, 64'd10, 64'd10, "rst_sub_eq");
    rst = 1'b0;
    run_op(4'b0010, 64'd10, 64'd12, "post_rst_add");

    // Randomized operations against the model.
    for (int i = 0; i < 400; i++) begin
      int          mode;
      logic [63:0] a;
      logic [63:0] b;
      mode = $urandom_range(0, 3);
      a    = pick_operand(mode == 3 ? 2 : mode);
      b    = (mode == 3) ? a : pick_operand($urandom_range(0, 2));
      run_op(4'($urandom_range(0, 14)), a, b, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu
